byte_serial_adder_seq: RTL and testbench
========================================

Name: byte_serial_adder_seq

Overview:
- Sequential stage feeding the team's combinational 8-bit ripple-carry adder datapath.
- Performs multi-precision add/subtract on operands streamed least-significant byte first, one byte pair per beat.
- Carry is chained across beats in a register.
- Each result byte is returned through a 1-deep registered output slice with valid/ready handshake.
- Sits between the operand-fetch stream and the result writeback stream.

Parameters:
- MAX_BYTES, 16, maximum beats per operation (operand width = 8*MAX_BYTES bits).
- IDX_W, 4, width of beat index; must satisfy 2**IDX_W >= MAX_BYTES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  stage can accept beat
- in_a  input  8  operand A byte
- in_b  input  8  operand B byte
- in_first  input  1  beat is least-significant byte of a new operation
- in_last  input  1  beat is most-significant byte of the operation
- in_sub  input  1  1 = A-B, 0 = A+B; sampled on first beat only
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result beat
- out_sum  output  8  result byte
- out_idx  output  IDX_W  beat index within operation (0 = LSB)
- out_last  output  1  final result byte of operation
- out_cout  output  1  carry out of this byte (borrow-free indicator when sub)
- out_ovf  output  1  signed overflow; meaningful only when out_last=1, else 0
- err  output  1  sticky protocol error flag

Behaviour:
- Reset: synchronous, active-high, one clock, one cycle sufficient. Forces the following:
  - out_valid=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_ovf=0, err=0.
  - Carry register=0, sub latch=0, state=IDLE.
  - Reset asserted mid-operation discards the operation and any held output beat.
- Handshake:
  - Input transfer occurs on in_valid & in_ready; output transfer on out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational pass-through of downstream ready; full throughput, 1 beat/cycle).
  - Latency: accepted beat appears on outputs the next cycle.
  - Outputs hold stable while out_valid & !out_ready.
- Arithmetic per accepted beat:
  - b_eff = sub ? ~in_b : in_b.
  - cin = first ? sub : carry_reg.
  - {cout, sum} = in_a + b_eff + cin (9-bit result).
  - carry_reg <= cout.
  - out_ovf = in_last & (in_a[7] == b_eff[7]) & (sum[7] != in_a[7]).
- FSM states:
  - IDLE: waiting for a first beat.
    - Accepted beat with in_first=1: latch sub=in_sub, idx=0, emit result. Go to RUN if in_last=0, else stay IDLE.
    - Accepted beat with in_first=0: beat consumed, no output produced, err<=1.
  - RUN: mid-operation; uses latched sub, ignores in_sub.
    - Accepted beat with in_first=0: idx increments, emit result. Go to IDLE if in_last=1.
    - Accepted beat with in_first=1: previous operation abandoned, err<=1. Beat is processed as a new first beat (idx=0, new sub, cin=new sub).
- Boundaries:
  - in_first & in_last on the same beat: single-byte operation; out_idx=0, out_last=1.
  - Beat index reaching MAX_BYTES-1 without in_last: that beat is forced out_last=1, err<=1, FSM returns to IDLE; out_ovf is computed for it.
  - Stall: no beat accepted while the slice is full and out_ready=0; carry_reg and idx unchanged.
  - Simultaneous output drain and input accept in one cycle: the slice reloads, no bubble.
  - err clears only on rst.

Test Plan:
- 16-bit add: beats (A,B) = (0xFF,0x01,first), (0x00,0x00,last), out_ready=1 -> out_sum 0x00 cout=1 idx0, then 0x01 cout=0 last=1 ovf=0; 1 cycle latency each.
- 16-bit sub 0x0100-0x0001: beats (0x00,0x01,first,sub=1), (0x01,0x00,last) -> sums 0xFF cout=0, then 0x00 cout=1 last=1 ovf=0.
- Single-byte signed overflow: 0x7F+0x01, first&last -> out_sum=0x80, out_cout=0, out_ovf=1, out_last=1, idx=0.
- Backpressure: out_ready=0 for 3 cycles after first result -> in_ready=0, out_sum stable; release -> second beat result correct using held carry, no beat lost or duplicated.
- Protocol error: a beat with in_first=0 in IDLE -> no out_valid, err=1; a new first beat mid-RUN -> restarts with idx=0, err stays 1.
- MAX_BYTES=4, 4 beats without in_last -> 4th result has out_last=1 and idx=3, err=1; rst mid-operation -> all outputs 0 the next cycle, next first beat processed normally.

Source files
------------

// File: rtl/byte_serial_adder_seq_if.sv
// Operand-beat and result-beat streams of the byte-serial adder stage.
// The sticky protocol error flag travels with the bus.
interface byte_serial_adder_seq_if #(
    parameter int IDX_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_first;
    logic             in_last;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_cout;
    logic             out_ovf;
    logic             err;

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, err
    );

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, err
    );
endinterface

// File: rtl/byte_serial_adder_seq.sv
// Multi-precision add/subtract over LSB-first byte beats, carry chained in a
// register, each result byte held in a 1-deep registered output slice.
module byte_serial_adder_seq #(
    parameter int MAX_BYTES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    byte_serial_adder_seq_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BYTES - 1);

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_sum_q, out_sum_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_ready;
    logic             accept;
    logic             emit;
    logic             sub_eff;
    logic             cin;
    logic [7:0]       b_eff;
    logic [8:0]       sum9;
    logic [IDX_W-1:0] beat_idx;
    logic             at_limit;
    logic             beat_last;
    logic             beat_ovf;
    logic             proto_err;

    // Slice refills in the same cycle it drains, so throughput stays at one beat per cycle.
    assign in_ready = !out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;
    assign emit     = accept & (bus.in_first | (state_q == RUN));

    always_comb begin
        sub_eff   = bus.in_first ? bus.in_sub : sub_q;
        b_eff     = sub_eff ? ~bus.in_b : bus.in_b;
        cin       = bus.in_first ? sub_eff : carry_q;
        sum9      = {1'b0, bus.in_a} + {1'b0, b_eff} + {8'b0, cin};
        beat_idx  = bus.in_first ? '0 : idx_q + IDX_W'(1);
        at_limit  = (beat_idx == LAST_IDX);
        beat_last = bus.in_last | at_limit;
        beat_ovf  = beat_last & (bus.in_a[7] == b_eff[7]) & (sum9[7] != bus.in_a[7]);
        // A stray continuation beat in IDLE, or a restart while RUN, are both protocol errors.
        proto_err = accept & (bus.in_first == (state_q == RUN));

        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        err_d       = err_q | proto_err | (emit & at_limit & !bus.in_last);

        if (emit) begin
            state_d     = beat_last ? IDLE : RUN;
            carry_d     = sum9[8];
            sub_d       = sub_eff;
            idx_d       = beat_idx;
            out_valid_d = 1'b1;
            out_sum_d   = sum9[7:0];
            out_idx_d   = beat_idx;
            out_last_d  = beat_last;
            out_cout_d  = sum9[8];
            out_ovf_d   = beat_ovf;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// Bench for byte_serial_adder_seq: vector table replayed with and without
// random backpressure, plus hand-written stall, error, limit and reset sequences.
module tb_byte_serial_adder_seq;
    localparam int MAXB = 4;
    localparam int IDXW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_serial_adder_seq_if #(.IDX_W(IDXW)) bus ();

    byte_serial_adder_seq #(.MAX_BYTES(MAXB), .IDX_W(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]      sum;
        logic [IDXW-1:0] idx;
        logic            last;
        logic            cout;
        logic            ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       first;
        logic       last;
        logic       sub;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[13];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic f, input logic l, input logic s,
                                input logic [7:0] es, input int ei,
                                input logic el, input logic ec, input logic eo);
        vec_t v;
        v.a = a; v.b = b; v.first = f; v.last = l; v.sub = s;
        v.e.sum = es; v.e.idx = IDXW'(ei); v.e.last = el; v.e.cout = ec; v.e.ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_first = v.first;
        bus.in_last  = v.last;
        bus.in_sub   = v.sub;
    endtask

    // Holds the beat until accepted; pushes its expectation when push=1.
    task automatic send(input vec_t v, input bit push);
        drive(v);
        for (int g = 0; g < 200; g++) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_ready) begin
                if (push) sb_q.push_back(v.e);
                tick();
                return;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never rose for a=0x%0h b=0x%0h", v.a, v.b);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 20; g++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        tick();
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_cout", bus.out_cout, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_err", bus.err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        tick();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: sum=0x%0h idx=%0d with empty scoreboard",
                             bus.out_sum, bus.out_idx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("beat out: sum=0x%02h idx=%0d last=%0b cout=%0b ovf=%0b (exp 0x%02h %0d %0b %0b %0b)",
                             bus.out_sum, bus.out_idx, bus.out_last, bus.out_cout, bus.out_ovf,
                             e.sum, e.idx, e.last, e.cout, e.ovf);
                    check("out_sum", bus.out_sum, e.sum);
                    check("out_idx", bus.out_idx, e.idx);
                    check("out_last", bus.out_last, e.last);
                    check("out_cout", bus.out_cout, e.cout);
                    check("out_ovf", bus.out_ovf, e.ovf);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        //              a      b      f  l  s   sum    idx last cout ovf
        tbl[0]  = mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[1]  = mk(8'h00, 8'h00, 0, 1, 0, 8'h01, 1, 1, 0, 0);
        tbl[2]  = mk(8'h00, 8'h01, 1, 0, 1, 8'hFF, 0, 0, 0, 0);
        tbl[3]  = mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 1, 1, 0);
        tbl[4]  = mk(8'h7F, 8'h01, 1, 1, 0, 8'h80, 0, 1, 0, 1);
        tbl[5]  = mk(8'h00, 8'h01, 1, 0, 1, 8'hFF, 0, 0, 0, 0);
        tbl[6]  = mk(8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 0, 0);
        tbl[7]  = mk(8'h00, 8'h00, 0, 1, 0, 8'hFF, 2, 1, 0, 0);
        tbl[8]  = mk(8'h80, 8'h01, 1, 1, 1, 8'h7F, 0, 1, 1, 1);
        tbl[9]  = mk(8'h80, 8'h80, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        tbl[10] = mk(8'h7F, 8'h00, 0, 1, 0, 8'h80, 1, 1, 0, 1);
        tbl[11] = mk(8'hA5, 8'h5A, 1, 1, 0, 8'hFF, 0, 1, 0, 0);
        tbl[12] = mk(8'h01, 8'hFF, 1, 1, 0, 8'h00, 0, 1, 1, 0);

        fork
            monitor();
        join_none

        repeat (2) tick();
        do_reset();

        // Back-to-back with the consumer always ready, then with random backpressure.
        for (int p = 0; p < 2; p++) begin
            rand_ready = (p == 1);
            for (int i = 0; i < 13; i++) send(tbl[i], 1'b1);
            rand_ready = 1'b0;
            drain();
            check("err_clean_stream", bus.err, 0);
        end

        // Stall with a pending beat: slice holds, carry is preserved across the stall.
        send(mk(8'hFF, 8'h01, 1, 0, 0, 8'h00, 0, 0, 1, 0), 1'b1);
        bus.out_ready = 1'b0;
        drive(mk(8'h00, 8'h00, 0, 1, 0, 8'h01, 1, 1, 0, 0));
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_sum", bus.out_sum, 8'h00);
            check("stall_out_cout", bus.out_cout, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        send(mk(8'h00, 8'h00, 0, 1, 0, 8'h01, 1, 1, 0, 0), 1'b1);
        drain();

        // Continuation beat in IDLE is swallowed and flags err.
        send(mk(8'h11, 8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        #1;
        check("stray_no_output", bus.out_valid, 0);
        check("stray_err", bus.err, 1);
        tick();
        // Restart mid-RUN: new op starts at idx 0 with fresh carry-in.
        send(mk(8'h10, 8'h20, 1, 0, 0, 8'h30, 0, 0, 0, 0), 1'b1);
        send(mk(8'h01, 8'h02, 1, 0, 0, 8'h03, 0, 0, 0, 0), 1'b1);
        send(mk(8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 1, 0, 0), 1'b1);
        drain();
        check("restart_err_sticky", bus.err, 1);

        // Reset while a result is held and the operation is mid-RUN.
        bus.out_ready = 1'b0;
        send(mk(8'hFF, 8'hFF, 1, 0, 0, 8'hFE, 0, 0, 1, 0), 1'b1);
        do_reset();
        send(mk(8'h01, 8'h01, 1, 1, 0, 8'h02, 0, 1, 0, 0), 1'b1);
        drain();
        check("post_reset_err", bus.err, 0);

        // Operation hitting MAX_BYTES without in_last is truncated there.
        send(mk(8'h01, 8'h01, 1, 0, 0, 8'h02, 0, 0, 0, 0), 1'b1);
        send(mk(8'h02, 8'h02, 0, 0, 0, 8'h04, 1, 0, 0, 0), 1'b1);
        send(mk(8'h03, 8'h03, 0, 0, 0, 8'h06, 2, 0, 0, 0), 1'b1);
        send(mk(8'h40, 8'h40, 0, 0, 0, 8'h80, 3, 1, 0, 1), 1'b1);
        send(mk(8'h05, 8'h05, 1, 1, 0, 8'h0A, 0, 1, 0, 0), 1'b1);
        drain();
        check("max_bytes_err", bus.err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
